tt_eval_seq: RTL and testbench
==============================

Name: tt_eval_seq

Overview:
- Programmable, pipelined N-input truth-table evaluator; the sequential, parametrised successor to our fixed single-function 4-input logic netlists.
- The function is a 2^N-bit truth table. It is loaded serially into a shadow register and committed atomically.
- Input vectors are evaluated through a 2-stage valid/ready pipeline.
- A built-in sweep mode walks all 2^N input combinations through the pipeline and compares the captured signature against an expected word. This self-checks a configured function such as 0x2FC7.

Parameters:
- N_IN, 4, number of logic inputs (1..6).
- TT_W, 2**N_IN, truth-table width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  serial config bit strobe.
- cfg_data  in  1  config bit, truth-table MSB (bit TT_W-1) first.
- cfg_ready  out  1  config bit accepted when cfg_valid&&cfg_ready.
- in_valid  in  1  input vector valid.
- in_data  in  N_IN  input vector; index = unsigned(in_data), in_data[N_IN-1] is MSB.
- in_ready  out  1  pipeline can accept.
- out_valid  out  1  result valid.
- out_data  out  1  TT[index].
- out_ready  in  1  downstream accepts.
- sweep_start  in  1  1-cycle pulse; start self-check.
- sweep_exp  in  TT_W  expected truth table, sampled on sweep_start.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  1-cycle pulse at sweep end.
- sweep_match  out  1  signature==expected; held until next sweep_start.
- sweep_sig  out  TT_W  captured signature; held.
- tt_active  out  TT_W  committed truth table (readback).

Behaviour:
- Reset, synchronous: tt_active=0, shadow=0, bit counter=0. out_valid=0, out_data=0, in_ready=1, cfg_ready=1. sweep_busy=0, sweep_done=0, sweep_match=0, sweep_sig=0. FSM=IDLE.
- rst asserted mid-load or mid-sweep aborts the operation. No commit occurs, and all outputs take their reset values on the next edge.
- Config load:
  - Each accepted bit shifts into the shadow LSB; bit counter increments modulo TT_W.
  - On the edge accepting bit TT_W-1, shadow (including that bit) is copied to tt_active and the counter returns to 0.
  - A partial load never affects tt_active.
  - cfg_ready=0 while sweep_busy.
- Evaluation pipeline:
  - S1 registers in_data. S2 registers out_data=tt_active[S1 index].
  - Latency is 2 edges from the accepting edge to out_valid.
  - in_ready = !sweep_busy && (!S1v || S2 can take). S2 can take = !S2v || out_ready.
  - The pipeline stalls without loss or duplication when out_ready=0.
  - The lookup uses tt_active as it stands at the S1->S2 edge. A commit on the same edge takes effect from the next edge.
- FSM states:
  - IDLE: sweep_start=1 -> DRAIN. A sweep_start while busy is ignored.
  - DRAIN: in_ready=0; wait until S1 and S2 are empty -> RUN.
  - RUN: inject index 0..TT_W-1, one per cycle, into S1 (stall rules apply).
    - S2 results are routed to sweep_sig[index], not the out port; out_valid stays 0 for sweep items.
    - After the last result is captured -> DONE.
  - DONE: one cycle; sweep_done=1, sweep_match=(sweep_sig==sweep_exp) -> IDLE.
- sweep_busy=1 in DRAIN, RUN and DONE.
- In RUN the sweep index counter is N_IN+1 bits wide, so the terminal compare at TT_W does not wrap.
- Simultaneous sweep_start with the final cfg bit: the commit happens first and the sweep uses the new table.

Decomposition:
- Package tt_eval_pkg: typedef sweep_state_t {IDLE, DRAIN, RUN, DONE}; function tt_width(n)=2**n; constant MAX_N_IN=6.
- One sub-module, tt_eval_pipe: the 2-stage valid/ready lookup pipeline with source mux tag (ext/sweep). The top holds the config shifter and the sweep FSM.

Test Plan:
- Reset then load 0x2FC7 (16 bits, MSB first). Then tt_active=0x2FC7 on the edge after bit 15. cfg_ready stays 1 throughout.
- After load, drive in_data=0,3,13,15 back-to-back with out_ready=1 -> out_data=1,0,1,0 at edges +2..+5; in_ready stays 1.
- Hold out_ready=0 for 4 cycles during a 4-vector burst -> in_ready drops after 2 accepted; all 4 results arrive in order, none lost or duplicated.
- Pulse sweep_start with sweep_exp=0x2FC7 -> sweep_busy high for 16 RUN cycles plus drain/done. Then sweep_done pulses, sweep_sig=0x2FC7, sweep_match=1, out_valid stays 0.
- Repeat the sweep with sweep_exp=0x2FC6 -> sweep_match=0 and sweep_sig=0x2FC7. Assert rst mid-sweep -> all outputs return to reset values and tt_active=0.
- N_IN=2 build: load 4'b0110 (XOR) -> inputs 0..3 give 0,1,1,0. Abort the load after 2 bits with rst -> tt_active remains 0.

Source files
------------

// File: rtl/tt_eval_seq_pkg.sv
// Shared definitions for the truth-table evaluator slice.
//   sweep_state_t : sweep sequencer states (IDLE, DRAIN, RUN, DONE)
//   MAX_N_IN      : largest supported number of logic inputs
//   tt_width(n)   : truth-table width for n inputs (2**n)
package tt_eval_pkg;

  localparam int MAX_N_IN = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  function automatic int tt_width(input int n);
    return 32'sd1 <<< n;
  endfunction

endpackage

// File: rtl/tt_eval_seq_if.sv
// Handshake bundle of the truth-table evaluator.
//   cfg_*  : serial truth-table load channel (one bit per transfer, MSB first)
//   in_*   : input-vector channel into the lookup pipeline
//   out_*  : lookup-result channel out of the pipeline
// The master modport is the environment side, the slave modport the evaluator side.
interface tt_eval_seq_if #(
  parameter int N_IN = 4
);

  logic            cfg_valid;
  logic            cfg_data;
  logic            cfg_ready;
  logic            in_valid;
  logic [N_IN-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_data;
  logic            out_ready;

  modport master (
    output cfg_valid, cfg_data,
    input  cfg_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready
  );

  modport slave (
    input  cfg_valid, cfg_data,
    output cfg_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready
  );

endinterface

// File: rtl/tt_eval_seq_pipe.sv
// Two-stage valid/ready lookup pipeline.
//   S1 registers the index and its source tag (external or sweep).
//   S2 registers tt_active[index]; external results leave on out_*,
//   sweep results leave on swp_* and are always consumed by the sweep logic.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   tt_active           : committed truth table used for the lookup
//   src_valid/idx/sweep : source item into S1; src_ready = S1 can accept
//   out_valid/data/ready: external result handshake
//   swp_valid/idx/data  : sweep result (one-cycle strobe)
//   empty               : no item held in S1 or S2
module tt_eval_pipe
  import tt_eval_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TT_W-1:0] tt_active,
  input  logic            src_valid,
  input  logic [N_IN-1:0] src_idx,
  input  logic            src_sweep,
  output logic            src_ready,
  output logic            out_valid,
  output logic            out_data,
  input  logic            out_ready,
  output logic            swp_valid,
  output logic [N_IN-1:0] swp_idx,
  output logic            swp_data,
  output logic            empty
);

  logic            s1_valid_r;
  logic [N_IN-1:0] s1_idx_r;
  logic            s1_sweep_r;
  logic            s2_ext_valid_r;
  logic            s2_swp_valid_r;
  logic [N_IN-1:0] s2_idx_r;
  logic            s2_data_r;
  logic            s2_take_s;

  // A sweep item in S2 is drained unconditionally, so only an external
  // result can hold S2.
  assign s2_take_s = !s2_ext_valid_r || out_ready;
  assign src_ready = !s1_valid_r || s2_take_s;

  // Pipeline stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r     <= 1'b0;
      s1_idx_r       <= {N_IN{1'b0}};
      s1_sweep_r     <= 1'b0;
      s2_ext_valid_r <= 1'b0;
      s2_swp_valid_r <= 1'b0;
      s2_idx_r       <= {N_IN{1'b0}};
      s2_data_r      <= 1'b0;
    end else begin
      if (s2_take_s) begin
        s2_ext_valid_r <= s1_valid_r && !s1_sweep_r;
        s2_swp_valid_r <= s1_valid_r && s1_sweep_r;
        if (s1_valid_r) begin
          // Lookup sees tt_active as it is before this edge; a commit on
          // the same edge only affects later lookups.
          s2_data_r <= tt_active[s1_idx_r];
          s2_idx_r  <= s1_idx_r;
        end
      end
      if (src_ready) begin
        s1_valid_r <= src_valid;
        if (src_valid) begin
          s1_idx_r   <= src_idx;
          s1_sweep_r <= src_sweep;
        end
      end
    end
  end

  assign out_valid = s2_ext_valid_r;
  assign out_data  = s2_data_r;
  assign swp_valid = s2_swp_valid_r;
  assign swp_idx   = s2_idx_r;
  assign swp_data  = s2_data_r;
  assign empty     = !s1_valid_r && !s2_ext_valid_r && !s2_swp_valid_r;

endmodule

// File: rtl/tt_eval_seq.sv
// Programmable N-input truth-table evaluator.
//   - Serial config: bits shift MSB first into a shadow register; the
//     edge accepting the last bit commits the full table to tt_active.
//   - Lookup: 2-stage valid/ready pipeline (tt_eval_pipe).
//   - Sweep: walks all 2**N_IN indices through the pipeline, collects the
//     results into sweep_sig and compares against sweep_exp.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus           : cfg/in/out handshakes (tt_eval_seq_if.slave)
//   sweep_start   : one-cycle pulse starting a sweep (ignored while busy)
//   sweep_exp     : expected table, sampled with sweep_start
//   sweep_busy    : sweep in progress (DRAIN, RUN, DONE)
//   sweep_done    : one-cycle pulse in DONE
//   sweep_match   : sweep_sig == sweep_exp, held until next sweep_start
//   sweep_sig     : captured signature
//   tt_active     : committed truth table
module tt_eval_seq
  import tt_eval_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int TT_W = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  tt_eval_seq_if.slave    bus,
  input  logic            sweep_start,
  input  logic [TT_W-1:0] sweep_exp,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic            sweep_match,
  output logic [TT_W-1:0] sweep_sig,
  output logic [TT_W-1:0] tt_active
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] CNT_ONE   = N_IN'(1'b1);
  // One bit wider than an index so the end-of-injection value is reachable.
  localparam logic [N_IN:0]   SWEEP_END = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN:0]   SWEEP_ONE = (N_IN + 1)'(1'b1);

  logic [TT_W-1:0] shadow_r;
  logic [N_IN-1:0] bit_cnt_r;
  logic [TT_W-1:0] tt_active_r;
  logic [TT_W-1:0] shadow_next_s;
  logic            cfg_fire_s;

  logic [1:0]      state_r;
  logic [N_IN:0]   sweep_idx_r;
  logic [TT_W-1:0] sweep_exp_r;
  logic [TT_W-1:0] sweep_sig_r;
  logic            sweep_done_r;
  logic            sweep_match_r;
  logic            sweep_busy_s;
  logic [TT_W-1:0] sig_next_s;

  logic            src_valid_s;
  logic [N_IN-1:0] src_idx_s;
  logic            src_sweep_s;
  logic            src_ready_s;
  logic            inject_s;
  logic            swp_valid_s;
  logic [N_IN-1:0] swp_idx_s;
  logic            swp_data_s;
  logic            last_cap_s;
  logic            pipe_empty_s;
  logic            pipe_out_valid_s;
  logic            pipe_out_data_s;

  assign sweep_busy_s  = (state_r != ST_IDLE);
  assign cfg_fire_s    = bus.cfg_valid && !sweep_busy_s;
  assign shadow_next_s = (TT_W > 1) ? {shadow_r[TT_W-2:0], bus.cfg_data} : TT_W'(bus.cfg_data);

  // Serial truth-table shifter with atomic commit on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r    <= {TT_W{1'b0}};
      bit_cnt_r   <= {N_IN{1'b0}};
      tt_active_r <= {TT_W{1'b0}};
    end else if (cfg_fire_s) begin
      shadow_r <= shadow_next_s;
      if (bit_cnt_r == IDX_LAST) begin
        tt_active_r <= shadow_next_s;
        bit_cnt_r   <= {N_IN{1'b0}};
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_ONE;
      end
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Pipeline source mux: sweep indices in RUN, external vectors otherwise.
  always_comb begin
    src_valid_s = 1'b0;
    src_idx_s   = {N_IN{1'b0}};
    src_sweep_s = 1'b0;
    if (state_r == ST_RUN) begin
      src_valid_s = (sweep_idx_r != SWEEP_END);
      src_idx_s   = sweep_idx_r[N_IN-1:0];
      src_sweep_s = 1'b1;
    end else begin
      src_valid_s = bus.in_valid && !sweep_busy_s;
      src_idx_s   = bus.in_data;
      src_sweep_s = 1'b0;
    end
  end

  assign inject_s   = (state_r == ST_RUN) && src_valid_s && src_ready_s;
  // Results return in order, so the last index closes the sweep.
  assign last_cap_s = swp_valid_s && (swp_idx_s == IDX_LAST);

  // Signature including the result arriving this cycle.
  always_comb begin
    sig_next_s = sweep_sig_r;
    if (swp_valid_s) begin
      sig_next_s[swp_idx_s] = swp_data_s;
    end else begin
      sig_next_s = sweep_sig_r;
    end
  end

  tt_eval_pipe #(
    .N_IN (N_IN),
    .TT_W (TT_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .tt_active (tt_active_r),
    .src_valid (src_valid_s),
    .src_idx   (src_idx_s),
    .src_sweep (src_sweep_s),
    .src_ready (src_ready_s),
    .out_valid (pipe_out_valid_s),
    .out_data  (pipe_out_data_s),
    .out_ready (bus.out_ready),
    .swp_valid (swp_valid_s),
    .swp_idx   (swp_idx_s),
    .swp_data  (swp_data_s),
    .empty     (pipe_empty_s)
  );

  // Sweep sequencer and its result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      sweep_idx_r   <= {(N_IN + 1){1'b0}};
      sweep_exp_r   <= {TT_W{1'b0}};
      sweep_sig_r   <= {TT_W{1'b0}};
      sweep_done_r  <= 1'b0;
      sweep_match_r <= 1'b0;
    end else begin
      sweep_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sweep_start) begin
            sweep_exp_r   <= sweep_exp;
            sweep_sig_r   <= {TT_W{1'b0}};
            sweep_match_r <= 1'b0;
            sweep_idx_r   <= {(N_IN + 1){1'b0}};
            state_r       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty_s) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (inject_s) begin
            sweep_idx_r <= sweep_idx_r + SWEEP_ONE;
          end
          if (swp_valid_s) begin
            sweep_sig_r <= sig_next_s;
          end
          if (last_cap_s) begin
            state_r       <= ST_DONE;
            sweep_done_r  <= 1'b1;
            sweep_match_r <= (sig_next_s == sweep_exp_r);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready = !sweep_busy_s;
  assign bus.in_ready  = !sweep_busy_s && src_ready_s;
  assign bus.out_valid = pipe_out_valid_s;
  assign bus.out_data  = pipe_out_data_s;
  assign sweep_busy    = sweep_busy_s;
  assign sweep_done    = sweep_done_r;
  assign sweep_match   = sweep_match_r;
  assign sweep_sig     = sweep_sig_r;
  assign tt_active     = tt_active_r;

endmodule

// File: tb/tb_tt_eval_seq.sv
// Directed bench for tt_eval_seq: an N_IN=4 instance and an N_IN=2 instance.
module tb_tt_eval_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rst2;
  logic        sweep_start4, sweep_start2;
  logic [15:0] sweep_exp4;
  logic [3:0]  sweep_exp2;
  logic        busy4, done4, match4, busy2, done2, match2;
  logic [15:0] sig4, tta4;
  logic [3:0]  sig2, tta2;

  tt_eval_seq_if #(.N_IN(4)) bus4 ();
  tt_eval_seq_if #(.N_IN(2)) bus2 ();

  tt_eval_seq #(.N_IN(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4.slave),
    .sweep_start(sweep_start4), .sweep_exp(sweep_exp4),
    .sweep_busy(busy4), .sweep_done(done4), .sweep_match(match4),
    .sweep_sig(sig4), .tt_active(tta4)
  );

  tt_eval_seq #(.N_IN(2)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2.slave),
    .sweep_start(sweep_start2), .sweep_exp(sweep_exp2),
    .sweep_busy(busy2), .sweep_done(done2), .sweep_match(match2),
    .sweep_sig(sig2), .tt_active(tta2)
  );

  typedef struct {
    logic [3:0] idx;
    logic       exp;
  } eval_vec_t;

  eval_vec_t tab4[12];
  eval_vec_t tab2[4];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset4(input string tag);
    chk({tag, "_out_valid"}, bus4.out_valid, 0);
    chk({tag, "_out_data"},  bus4.out_data, 0);
    chk({tag, "_in_ready"},  bus4.in_ready, 1);
    chk({tag, "_cfg_ready"}, bus4.cfg_ready, 1);
    chk({tag, "_busy"},      busy4, 0);
    chk({tag, "_done"},      done4, 0);
    chk({tag, "_match"},     match4, 0);
    chk({tag, "_sig"},       sig4, 0);
    chk({tag, "_tt_active"}, tta4, 0);
  endtask

  // Starts a sweep on dut4 and waits (bounded) for sweep_done.
  task automatic run_sweep4(input logic [15:0] exp, output int busy_cyc, output int done_cnt,
                            output int ov_cnt, output int rdy_cnt, output logic match_at_start);
    sweep_exp4 = exp;
    sweep_start4 = 1'b1;
    tick();
    sweep_start4 = 1'b0;
    match_at_start = match4;
    busy_cyc = 0; done_cnt = 0; ov_cnt = 0; rdy_cnt = 0;
    for (int c = 0; c < 60 && done_cnt == 0; c++) begin
      if (busy4) busy_cyc++;
      if (bus4.out_valid) ov_cnt++;
      if (busy4 && (bus4.cfg_ready || bus4.in_ready)) rdy_cnt++;
      if (done4) done_cnt++;
      else tick();
    end
  endtask

  task automatic load2(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) begin
      bus2.cfg_valid = 1'b1;
      bus2.cfg_data  = v[i];
      tick();
    end
    bus2.cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cyc, done_cnt, ov_cnt, rdy_cnt, sent, rcv, blk, bi;
    logic m_start, took, rdy_all;
    logic [15:0] tt_val;

    // idx -> expected bit of 0x2FC7; entries 8..11 are the stall burst
    tab4[0]  = '{4'd0, 1'b1};  tab4[1]  = '{4'd3, 1'b0};
    tab4[2]  = '{4'd13, 1'b1}; tab4[3]  = '{4'd15, 1'b0};
    tab4[4]  = '{4'd1, 1'b1};  tab4[5]  = '{4'd2, 1'b1};
    tab4[6]  = '{4'd6, 1'b1};  tab4[7]  = '{4'd5, 1'b0};
    tab4[8]  = '{4'd12, 1'b0}; tab4[9]  = '{4'd8, 1'b1};
    tab4[10] = '{4'd4, 1'b0};  tab4[11] = '{4'd11, 1'b1};
    // XOR table 4'b0110
    tab2[0] = '{4'd0, 1'b0}; tab2[1] = '{4'd1, 1'b1};
    tab2[2] = '{4'd2, 1'b1}; tab2[3] = '{4'd3, 1'b0};

    bus4.cfg_valid = 1'b0; bus4.cfg_data = 1'b0; bus4.in_valid = 1'b0;
    bus4.in_data = 4'd0; bus4.out_ready = 1'b1;
    bus2.cfg_valid = 1'b0; bus2.cfg_data = 1'b0; bus2.in_valid = 1'b0;
    bus2.in_data = 2'd0; bus2.out_ready = 1'b1;
    sweep_start4 = 1'b0; sweep_exp4 = 16'd0;
    sweep_start2 = 1'b0; sweep_exp2 = 4'd0;
    rst4 = 1'b1; rst2 = 1'b1;
    tick(); tick();
    chk_reset4("reset");
    chk("reset2_tt_active", tta2, 0);
    rst4 = 1'b0; rst2 = 1'b0;

    // ---- load 0x2FC7 MSB first; commit on the edge accepting bit 15 ----
    tt_val = 16'h2FC7;
    rdy_all = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      bus4.cfg_valid = 1'b1;
      bus4.cfg_data  = tt_val[i];
      #1;
      rdy_all = rdy_all & bus4.cfg_ready;
      tick();
      if (i == 1) chk("tt_before_last_bit", tta4, 0);
    end
    bus4.cfg_valid = 1'b0;
    chk("tt_after_load", tta4, 32'h2FC7);
    chk("cfg_ready_during_load", rdy_all, 1);

    // ---- back-to-back stream, out_ready=1, 2-edge latency ----
    bus4.out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        bus4.in_valid = 1'b1;
        bus4.in_data  = tab4[k].idx;
      end else begin
        bus4.in_valid = 1'b0;
      end
      #1;
      if (k < 8) chk("stream_in_ready", bus4.in_ready, 1);
      tick();
      if (k >= 1) begin
        chk("stream_out_valid", bus4.out_valid, 1);
        chk($sformatf("stream_out_data_idx%0d", tab4[k-1].idx), bus4.out_data, tab4[k-1].exp);
      end else begin
        chk("stream_latency_not_1", bus4.out_valid, 0);
      end
    end
    tick();
    chk("stream_drained", bus4.out_valid, 0);

    // ---- 4-vector burst with out_ready low for 4 cycles ----
    sent = 0; rcv = 0; blk = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bi = (sent < 4) ? sent : 0;
      bus4.in_valid  = (sent < 4);
      bus4.in_data   = tab4[8 + bi].idx;
      bus4.out_ready = (cyc >= 4);
      #1;
      if (bus4.in_valid && !bus4.in_ready && blk < 0) blk = sent;
      if (bus4.out_valid && bus4.out_ready) begin
        if (rcv < 4) chk($sformatf("burst_data_%0d", rcv), bus4.out_data, tab4[8 + rcv].exp);
        rcv++;
      end
      took = bus4.in_valid && bus4.in_ready;
      tick();
      if (took) sent++;
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    chk("burst_stall_after_accepts", blk, 2);
    chk("burst_sent", sent, 4);
    chk("burst_received", rcv, 4);

    // ---- sweep with matching expectation ----
    run_sweep4(16'h2FC7, busy_cyc, done_cnt, ov_cnt, rdy_cnt, m_start);
    chk("sweep1_done_seen", done_cnt, 1);
    chk("sweep1_busy_len_in_range", (busy_cyc >= 18 && busy_cyc <= 24), 1);
    chk("sweep1_sig", sig4, 32'h2FC7);
    chk("sweep1_match", match4, 1);
    chk("sweep1_out_valid_quiet", ov_cnt, 0);
    chk("sweep1_ready_low_while_busy", rdy_cnt, 0);
    tick();
    chk("sweep1_done_pulse_len", done4, 0);
    chk("sweep1_busy_clear", busy4, 0);
    tick(); tick();
    chk("sweep1_match_held", match4, 1);
    chk("sweep1_sig_held", sig4, 32'h2FC7);

    // ---- sweep with mismatching expectation ----
    run_sweep4(16'h2FC6, busy_cyc, done_cnt, ov_cnt, rdy_cnt, m_start);
    chk("sweep2_match_cleared_on_start", m_start, 0);
    chk("sweep2_done_seen", done_cnt, 1);
    chk("sweep2_sig", sig4, 32'h2FC7);
    chk("sweep2_match", match4, 0);
    tick();

    // ---- reset in the middle of a sweep ----
    sweep_exp4 = 16'h2FC7;
    sweep_start4 = 1'b1;
    tick();
    sweep_start4 = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    chk("sweep3_busy_before_rst", busy4, 1);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    chk_reset4("midsweep_rst");
    tick();
    chk("midsweep_rst_stays_idle", busy4, 0);

    // ---- N_IN=2: XOR table ----
    load2(4'b0110);
    chk("n2_tt_active", tta2, 4'b0110);
    for (int k = 0; k < 4; k++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data  = tab2[k].idx[1:0];
      tick();
      bus2.in_valid = 1'b0;
      tick();
      chk("n2_out_valid", bus2.out_valid, 1);
      chk($sformatf("n2_out_data_idx%0d", k), bus2.out_data, tab2[k].exp);
    end
    tick();

    // partial load does not commit; rst aborts it
    bus2.cfg_valid = 1'b1;
    bus2.cfg_data  = 1'b1;
    tick(); tick();
    chk("n2_partial_no_commit", tta2, 4'b0110);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    bus2.cfg_valid = 1'b0;
    chk("n2_abort_tt_active", tta2, 0);
    chk("n2_abort_cfg_ready", bus2.cfg_ready, 1);

    // final cfg bit together with sweep_start: sweep sees the new table
    for (int i = 3; i >= 1; i--) begin
      bus2.cfg_valid = 1'b1;
      bus2.cfg_data  = (i == 3);
      tick();
    end
    chk("n2_before_commit", tta2, 0);
    bus2.cfg_data = 1'b1;
    sweep_exp2 = 4'b1001;
    sweep_start2 = 1'b1;
    tick();
    bus2.cfg_valid = 1'b0;
    sweep_start2 = 1'b0;
    chk("n2_commit_with_start", tta2, 4'b1001);
    chk("n2_sweep_busy", busy2, 1);
    done_cnt = 0;
    for (int c = 0; c < 30 && done_cnt == 0; c++) begin
      if (done2) done_cnt++;
      else tick();
    end
    chk("n2_sweep_done_seen", done_cnt, 1);
    chk("n2_sweep_sig", sig2, 4'b1001);
    chk("n2_sweep_match", match2, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
